// File: rtl/pixel_stream_converter_if.sv
// pixel_stream_converter_if
//   AXI4-Stream style handshake bundle used for both sides of the pixel
//   stream converter.
//   Parameter DATA_W : payload width (16 for RGBA4444 input, 8 for RGB565 bytes).
//   Signals:
//     tvalid - source has a beat
//     tready - sink accepts the beat
//     tlast  - beat ends the frame
//     tdata  - payload
//   Modports: master drives tvalid/tlast/tdata, slave drives tready.
interface pixel_stream_converter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (
    output tvalid,
    output tlast,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/pixel_stream_converter.sv
// pixel_stream_converter
//   Converts a stream of RGBA4444 framebuffer pixels into a byte stream of
//   RGB565 display data. Each accepted pixel is converted on entry and held
//   in a small FIFO as {tlast, RGB565}; an output FSM (IDLE/BYTE0/BYTE1)
//   pops one word at a time and emits it as two bytes.
//   Parameter FIFO_DEPTH : FIFO entries, power of two, >= 2.
//   Ports:
//     clk        - rising-edge clock
//     resetn     - asynchronous active-low reset
//     sAxis      - slave stream, 16-bit RGBA4444 pixels
//     mAxis      - master stream, 8-bit RGB565 bytes
//     frame_done - one-cycle pulse in the cycle after the tlast byte is taken
//     busy       - FIFO non-empty or a word is being sent
//   Build option: define PIXEL_STREAM_BYTE_SWAP_EN to send the low byte
//   first; tlast always marks the second byte of the last word.
module pixel_stream_converter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  pixel_stream_converter_if.slave   sAxis,
  pixel_stream_converter_if.master  mAxis,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PtrOne    = AW'(1);
  localparam logic [AW:0]   CountOne  = (AW+1)'(1);
  localparam logic [AW:0]   FullCount = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    BYTE1
  } state_t;

  state_t state;

  logic [16:0]   fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic [AW:0]   countNext;

  logic [16:0] inEntry;
  logic [16:0] headEntry;
  logic        push;
  logic        pop;
  logic        accept;
  logic        stayActive;

  logic [15:0] word;
  logic        wordLast;

  logic        sReady;
  logic        mValid;
  logic        mLast;
  logic [7:0]  mData;
  logic        frameDone;
  logic        busyReg;

  // R/G/B nibbles widened by replicating their top bits; alpha never enters.
  function automatic logic [15:0] toRgb565(input logic [11:0] rgb);
    return {rgb[11:8], rgb[11], rgb[7:4], rgb[7:6], rgb[3:0], rgb[3]};
  endfunction

  function automatic logic [7:0] firstByte(input logic [15:0] w);
`ifdef PIXEL_STREAM_BYTE_SWAP_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  function automatic logic [7:0] secondByte(input logic [15:0] w);
`ifdef PIXEL_STREAM_BYTE_SWAP_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  always_comb begin
    inEntry   = {sAxis.tlast, toRgb565(sAxis.tdata[15:4])};
    headEntry = fifoMem[rdPtr];
    accept    = mValid && mAxis.tready;
    // sReady is the registered "not full" flag, so a full FIFO refuses the
    // push even when a pop happens in the same cycle.
    push      = sAxis.tvalid && sReady;
    pop       = (count != '0) && ((state == IDLE) || ((state == BYTE1) && accept));
    // A word stays in flight unless BYTE1 drains with nothing to reload.
    stayActive = pop || (state == BYTE0) || ((state == BYTE1) && !accept);
    countNext = count;
    if (push && !pop) begin
      countNext = count + CountOne;
    end else if (pop && !push) begin
      countNext = count - CountOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= inEntry;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      word      <= '0;
      wordLast  <= 1'b0;
      sReady    <= 1'b0;
      mValid    <= 1'b0;
      mLast     <= 1'b0;
      mData     <= '0;
      frameDone <= 1'b0;
      busyReg   <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PtrOne;
      end
      if (pop) begin
        rdPtr <= rdPtr + PtrOne;
      end
      count     <= countNext;
      sReady    <= (countNext != FullCount);
      busyReg   <= (countNext != '0) || stayActive;
      frameDone <= (state == BYTE1) && accept && mLast;

      case (state)
        IDLE: begin
          if (pop) begin
            word     <= headEntry[15:0];
            wordLast <= headEntry[16];
            mValid   <= 1'b1;
            mData    <= firstByte(headEntry[15:0]);
            mLast    <= 1'b0;
            state    <= BYTE0;
          end
        end
        BYTE0: begin
          if (accept) begin
            mData <= secondByte(word);
            mLast <= wordLast;
            state <= BYTE1;
          end
        end
        BYTE1: begin
          if (accept) begin
            mLast <= 1'b0;
            if (pop) begin
              word     <= headEntry[15:0];
              wordLast <= headEntry[16];
              mData    <= firstByte(headEntry[15:0]);
              state    <= BYTE0;
            end else begin
              mValid <= 1'b0;
              mData  <= '0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          mValid <= 1'b0;
          mLast  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign sAxis.tready = sReady;
  assign mAxis.tvalid = mValid;
  assign mAxis.tlast  = mLast;
  assign mAxis.tdata  = mData;
  assign frame_done   = frameDone;
  assign busy         = busyReg;

endmodule
